sparse_index_streamer: RTL and testbench

SPARSE_INDEX_STREAMER -- requirements
Module: sparse_index_streamer

---
 rtl/sparse_idx_pkg.sv | 18 +
 rtl/sparse_index_streamer_if.sv | 26 ++
 rtl/idx_popcount.sv | 17 +
 rtl/sparse_index_streamer.sv | 149 ++++++++++++++
 tb/tb_sparse_index_streamer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/sparse_idx_pkg.sv
// Shared defaults, per-layer word-count table and FSM state type for the
// sparse index streamer.
package sparse_idx_pkg;

    localparam int DEF_NUM_LAYERS = 9;
    localparam int DEF_WORD_W     = 27;
    localparam int DEF_MAX_WORDS  = 24;

    // Index words per layer, layer 1 first; every entry lies in 1..MAX_WORDS.
    localparam int DEF_WORDS_PER_LAYER [DEF_NUM_LAYERS] = '{1, 12, 12, 12, 24, 24, 24, 4, 4};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/sparse_index_streamer_if.sv
// Index-word stream handshake between the streamer (master) and its consumer.
interface sparse_index_streamer_if #(
    parameter int WORD_W = 27
);
    logic [WORD_W-1:0]          idx_word;
    logic                       idx_valid;
    logic                       idx_ready;
    logic                       idx_last;
    logic [$clog2(WORD_W+1)-1:0] idx_nnz;

    modport master (
        output idx_word,
        output idx_valid,
        output idx_last,
        output idx_nnz,
        input  idx_ready
    );

    modport slave (
        input  idx_word,
        input  idx_valid,
        input  idx_last,
        input  idx_nnz,
        output idx_ready
    );
endinterface

// File: rtl/idx_popcount.sv
// Combinational count of set bits in one kernel mask word.
module idx_popcount #(
    parameter int WORD_W = 27
) (
    input  logic [WORD_W-1:0]           word,
    output logic [$clog2(WORD_W+1)-1:0] cnt
);
    localparam int CNT_W = $clog2(WORD_W + 1);

    // Sum the mask bits.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < WORD_W; i++) begin
            cnt = cnt + CNT_W'(word[i]);
        end
    end
endmodule

// File: rtl/sparse_index_streamer.sv
// Holds one sparsity mask table per layer and, on request, streams the
// selected layer's index words over a valid/ready handshake with the
// popcount of each word alongside.
module sparse_index_streamer
    import sparse_idx_pkg::*;
#(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int WORD_W     = DEF_WORD_W,
    parameter int MAX_WORDS  = DEF_MAX_WORDS,
    parameter int WORDS_PER_LAYER [NUM_LAYERS] = DEF_WORDS_PER_LAYER
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ld_we,
    input  logic [3:0]                   ld_layer,
    input  logic [$clog2(MAX_WORDS)-1:0] ld_word,
    input  logic [WORD_W-1:0]            ld_data,
    input  logic                         start,
    input  logic [3:0]                   layer_sel,
    sparse_index_streamer_if.master      idx,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);
    localparam int LYR_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int PTR_W = $clog2(MAX_WORDS);

    logic [WORD_W-1:0] tbl [NUM_LAYERS][MAX_WORDS];

    state_e            state_q, state_d;
    logic [LYR_W-1:0]  lyr_q, lyr_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              last_q, last_d;
    logic              err_q, err_d;

    logic              sel_ok;
    logic [LYR_W-1:0]  sel_idx;
    logic              wr_ok;
    logic [LYR_W-1:0]  wr_lyr;
    logic [PTR_W-1:0]  ptr_nx;

    // Layers are numbered from 1 externally and from 0 internally.
    assign sel_ok  = (int'(layer_sel) >= 1) && (int'(layer_sel) <= NUM_LAYERS);
    assign sel_idx = LYR_W'(layer_sel - 4'd1);
    assign wr_ok   = ld_we && !busy && (int'(ld_layer) >= 1) && (int'(ld_layer) <= NUM_LAYERS)
                     && (int'(ld_word) < MAX_WORDS);
    assign wr_lyr  = LYR_W'(ld_layer - 4'd1);
    assign ptr_nx  = ptr_q + PTR_W'(1);

    // Table storage: cleared on reset, loadable only while no stream is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < NUM_LAYERS; l++) begin
                for (int w = 0; w < MAX_WORDS; w++) begin
                    tbl[l][w] <= '0;
                end
            end
        end else if (wr_ok) begin
            tbl[wr_lyr][ld_word] <= ld_data;
        end
    end

    // Next state plus the registered word/last that the consumer sees.
    always_comb begin
        state_d = state_q;
        lyr_d   = lyr_q;
        ptr_d   = ptr_q;
        word_d  = word_q;
        last_d  = last_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                word_d = '0;
                last_d = 1'b0;
                if (start) begin
                    if (sel_ok) begin
                        state_d = STREAM;
                        lyr_d   = sel_idx;
                        ptr_d   = '0;
                        word_d  = tbl[sel_idx][0];
                        last_d  = (WORDS_PER_LAYER[sel_idx] == 1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                // Without ready everything holds, so the word stays stable.
                if (idx.idx_ready) begin
                    if (last_q) begin
                        state_d = DONE;
                        ptr_d   = '0;
                        word_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        ptr_d  = ptr_nx;
                        word_d = tbl[lyr_q][ptr_nx];
                        last_d = (WORDS_PER_LAYER[lyr_q] == int'(ptr_q) + 2);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                word_d  = '0;
                last_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
                word_d  = '0;
                last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lyr_q   <= '0;
            ptr_q   <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lyr_q   <= lyr_d;
            ptr_q   <= ptr_d;
            word_q  <= word_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign busy          = (state_q == STREAM);
    assign done          = (state_q == DONE);
    assign err           = err_q;
    assign idx.idx_valid = (state_q == STREAM);
    assign idx.idx_word  = word_q;
    assign idx.idx_last  = last_q;

    // word_q is zero outside STREAM, so the count is zero there as well.
    idx_popcount #(.WORD_W(WORD_W)) u_popcount (
        .word (word_q),
        .cnt  (idx.idx_nnz)
    );

endmodule

// File: tb/tb_sparse_index_streamer.sv
// Directed bench for sparse_index_streamer: single-word layer, full-length
// layer, stalled stream, rejected starts, writes/starts during a stream and
// reset in the middle of a stream.
module tb_sparse_index_streamer;

    localparam int WORD_W = 27;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        ld_we = 1'b0;
    logic [3:0]  ld_layer = '0;
    logic [4:0]  ld_word = '0;
    logic [26:0] ld_data = '0;
    logic        start = 1'b0;
    logic [3:0]  layer_sel = '0;
    logic        busy, done, err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sparse_index_streamer_if #(.WORD_W(WORD_W)) idx_if ();

    sparse_index_streamer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_we     (ld_we),
        .ld_layer  (ld_layer),
        .ld_word   (ld_word),
        .ld_data   (ld_data),
        .start     (start),
        .layer_sel (layer_sel),
        .idx       (idx_if),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int l, input int w, input int d);
        ld_we    = 1'b1;
        ld_layer = 4'(l);
        ld_word  = 5'(w);
        ld_data  = 27'(d);
        tick();
        ld_we    = 1'b0;
    endtask

    task automatic go(input int l);
        start     = 1'b1;
        layer_sel = 4'(l);
        tick();
        start     = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_err"},   32'(err), 32'd0);
        chk({tag, "_valid"}, 32'(idx_if.idx_valid), 32'd0);
        chk({tag, "_word"},  32'(idx_if.idx_word), 32'd0);
        chk({tag, "_last"},  32'(idx_if.idx_last), 32'd0);
        chk({tag, "_nnz"},   32'(idx_if.idx_nnz), 32'd0);
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int ptr;
        int c;
        bit rdy;
        idx_if.idx_ready = 1'b0;

        // Reset
        #2 rst_n = 1'b0;
        #1 chk_quiet("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single-word layer 1
        wr(1, 0, 27'h5A5A5A5);
        idx_if.idx_ready = 1'b1;
        go(1);
        chk("l1_valid", 32'(idx_if.idx_valid), 32'd1);
        chk("l1_busy",  32'(busy), 32'd1);
        chk("l1_word",  32'(idx_if.idx_word), 32'h05A5A5A5);
        chk("l1_last",  32'(idx_if.idx_last), 32'd1);
        chk("l1_nnz",   32'(idx_if.idx_nnz), 32'd14);
        tick();
        chk("l1_done",  32'(done), 32'd1);
        chk("l1_dbusy", 32'(busy), 32'd0);
        chk("l1_dvld",  32'(idx_if.idx_valid), 32'd0);
        chk("l1_dword", 32'(idx_if.idx_word), 32'd0);
        tick();
        chk("l1_done_clr", 32'(done), 32'd0);

        // Layer 5, 24 words back to back
        for (int j = 0; j < 24; j++) wr(5, j, j);
        idx_if.idx_ready = 1'b1;
        go(5);
        for (int i = 0; i < 24; i++) begin
            chk("l5_valid", 32'(idx_if.idx_valid), 32'd1);
            chk("l5_word",  32'(idx_if.idx_word), 32'(i));
            chk("l5_last",  32'(idx_if.idx_last), 32'(i == 23));
            tick();
        end
        chk("l5_done", 32'(done), 32'd1);
        tick();

        // Layer 2 with ready pattern 1,0,0,1
        for (int j = 0; j < 12; j++) wr(2, j, 27'h0111111 * (j + 1));
        idx_if.idx_ready = 1'b0;
        go(2);
        ptr = 0;
        c   = 0;
        while (ptr < 12 && c < 100) begin
            rdy = pat[c % 4];
            idx_if.idx_ready = rdy;
            chk("l2_valid", 32'(idx_if.idx_valid), 32'd1);
            chk("l2_word",  32'(idx_if.idx_word), 32'h0111111 * 32'(ptr + 1));
            chk("l2_last",  32'(idx_if.idx_last), 32'(ptr == 11));
            chk("l2_nnz",   32'(idx_if.idx_nnz), 32'($countones(27'h0111111 * 27'(ptr + 1))));
            tick();
            if (rdy) ptr++;
            c++;
        end
        chk("l2_xfers", 32'(ptr), 32'd12);
        chk("l2_done",  32'(done), 32'd1);
        tick();

        // Rejected starts
        go(0);
        chk("sel0_err",   32'(err), 32'd1);
        chk("sel0_busy",  32'(busy), 32'd0);
        chk("sel0_valid", 32'(idx_if.idx_valid), 32'd0);
        tick();
        chk("sel0_err_clr", 32'(err), 32'd0);
        go(10);
        chk("sel10_err",   32'(err), 32'd1);
        chk("sel10_busy",  32'(busy), 32'd0);
        chk("sel10_valid", 32'(idx_if.idx_valid), 32'd0);
        tick();
        chk("sel10_err_clr", 32'(err), 32'd0);

        // Write and start attempts while layer 3 streams
        for (int j = 0; j < 12; j++) wr(3, j, 27'h3000 + j);
        idx_if.idx_ready = 1'b0;
        go(3);
        chk("l3_w0", 32'(idx_if.idx_word), 32'h3000);
        ld_we = 1'b1; ld_layer = 4'd3; ld_word = 5'd0; ld_data = 27'h7FFFFFF;
        start = 1'b1; layer_sel = 4'd0;
        tick();
        ld_we = 1'b0;
        chk("l3_noerr0", 32'(err), 32'd0);
        chk("l3_busy",   32'(busy), 32'd1);
        chk("l3_hold0",  32'(idx_if.idx_word), 32'h3000);
        layer_sel = 4'd1;
        tick();
        start = 1'b0;
        chk("l3_noerr1", 32'(err), 32'd0);
        chk("l3_hold1",  32'(idx_if.idx_word), 32'h3000);
        idx_if.idx_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            chk("l3_word", 32'(idx_if.idx_word), 32'h3000 + 32'(j));
            tick();
        end
        chk("l3_done", 32'(done), 32'd1);
        tick();
        idx_if.idx_ready = 1'b0;
        go(3);
        chk("l3_reread", 32'(idx_if.idx_word), 32'h3000);
        idx_if.idx_ready = 1'b1;
        wait_done("l3_redone", 40);
        tick();

        // Reset in the middle of layer 7
        for (int j = 0; j < 24; j++) wr(7, j, 27'h700 + j);
        idx_if.idx_ready = 1'b1;
        go(7);
        for (int i = 0; i < 6; i++) tick();
        chk("l7_w6", 32'(idx_if.idx_word), 32'h706);
        rst_n = 1'b0;
        #1;
        chk_quiet("l7_rst");
        tick();
        chk("l7_rst_nodone", 32'(done), 32'd0);
        rst_n = 1'b1;
        idx_if.idx_ready = 1'b0;
        go(7);
        chk("l7_restart_valid", 32'(idx_if.idx_valid), 32'd1);
        chk("l7_cleared_word",  32'(idx_if.idx_word), 32'd0);
        chk("l7_cleared_nnz",   32'(idx_if.idx_nnz), 32'd0);
        idx_if.idx_ready = 1'b1;
        wait_done("l7_done", 40);
        tick();
        idx_if.idx_ready = 1'b0;
        go(1);
        chk("l1_cleared", 32'(idx_if.idx_word), 32'd0);
        idx_if.idx_ready = 1'b1;
        wait_done("l1_cleared_done", 10);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
